// File: rtl/xor_stream_dec.sv
// Receive-side XOR stream decryptor.
// A frame is opened by a start pulse in IDLE, which latches the key and the
// frame length. Each ciphertext byte is XORed with the current key, and the
// key then rotates left by one position when ROLL_EN is set. One output
// register gives a one-cycle latency at full rate.
//
// Handshake rule, the same on both sides: a byte moves when valid and ready
// are both high at a rising clock edge. A producer holding valid=1 while the
// other side has ready=0 keeps its data stable. When a byte enters and a byte
// leaves in the same cycle, both take effect, and the new plaintext byte
// replaces the old one in the output register.
module xor_stream_dec #(
  parameter int ROLL_EN = 1,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       key_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [7:0]       key_cur;
  logic [7:0]       key_next;
  logic [LEN_W-1:0] len_r;
  logic             in_fire;
  logic             out_fire;
  logic             last_byte;

  // Input side opens only in RUN, and only while the output register
  // is empty or is being drained in this same cycle.
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  // The byte being accepted is the final one of the frame.
  assign last_byte = (byte_cnt == (len_r - LEN_W'(1)));

  // Key for the next byte: rotate left by one position, or hold it fixed.
  assign key_next = (ROLL_EN != 0) ? {key_cur[6:0], key_cur[7]} : key_cur;

  // Frame FSM together with the output register, the key and the byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      key_cur   <= 8'h00;
      len_r     <= '0;
      byte_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_cur  <= key_in;
            len_r    <= len_in;
            byte_cnt <= '0;
            state    <= (len_in != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (in_fire) begin
            out_data  <= in_data ^ key_cur;
            out_valid <= 1'b1;
            out_last  <= last_byte;
            byte_cnt  <= byte_cnt + LEN_W'(1);
            key_cur   <= key_next;
            if (last_byte) state <= S_DRAIN;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The only byte left in DRAIN is the one marked last.
          if (out_fire && out_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
